// File: rtl/tusca_pkg.sv
// tusca_uc shared types: controller state encoding and debug width.
// The optional watchdog is enabled by TUSCA_UC_WATCHDOG_EN.
package tusca_pkg;

    localparam int DB_W = 4;

    typedef enum logic [DB_W-1:0] {
        INICIAL          = 4'd0,
        PEDE_CONFIG      = 4'd1,
        ESPERA_CONFIG    = 4'd2,
        MEDE             = 4'd3,
        ESPERA_MEDIDA    = 4'd4,
        TRANSMITE        = 4'd5,
        ESPERA_TRANSMITE = 4'd6,
        AGUARDA          = 4'd7,
        ERRO             = 4'd15
    } estado_t;

    function automatic logic is_espera(estado_t s);
        return (s == ESPERA_CONFIG) || (s == ESPERA_MEDIDA) ||
               (s == ESPERA_TRANSMITE);
    endfunction

endpackage

// File: rtl/tusca_uc_if.sv
// Datapath handshake bundle between tusca_uc (master) and its datapath.
interface tusca_uc_if;

    logic pronto_config;
    logic erro_config;
    logic pronto_medida;
    logic erro_medida;
    logic pronto_transmite_medida;
    logic fim_delay;

    logic receber_config;
    logic medir_dht11;
    logic transmite_medida;
    logic zera_delay;
    logic conta_delay;
    logic gira;

    modport master (
        input  pronto_config, erro_config, pronto_medida, erro_medida,
        input  pronto_transmite_medida, fim_delay,
        output receber_config, medir_dht11, transmite_medida,
        output zera_delay, conta_delay, gira
    );

    modport slave (
        output pronto_config, erro_config, pronto_medida, erro_medida,
        output pronto_transmite_medida, fim_delay,
        input  receber_config, medir_dht11, transmite_medida,
        input  zera_delay, conta_delay, gira
    );

endinterface

// File: rtl/tusca_uc_watchdog.sv
// watchdog_uc: counts cycles while conta=1; fim flags the last allowed cycle.
module watchdog_uc #(
    parameter int unsigned TIMEOUT_CICLOS = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [W-1:0] LIM = W'(TIMEOUT_CICLOS - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (zera) begin
            cnt <= '0;
        end else if (conta && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign fim = conta && (cnt == LIM);

endmodule

// File: rtl/tusca_uc.sv
// tusca_uc: Moore controller sequencing config, measurement and transmit.
// Define TUSCA_UC_WATCHDOG_EN to add a timeout on every ESPERA_* state.
module tusca_uc
    import tusca_pkg::*;
#(
    parameter int MAX_TENTATIVAS = 3,
    parameter int TIMEOUT_CICLOS = 50_000_000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ligar,
    input  logic            atualizar_config,
    tusca_uc_if.master      dp,
    output logic            pronto_ciclo,
    output logic            erro,
    output logic [DB_W-1:0] db_estado
);

    localparam int CW = $clog2(MAX_TENTATIVAS + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_TENTATIVAS);

    if (TIMEOUT_CICLOS < 1) begin : g_bad_timeout
        $error("TIMEOUT_CICLOS must be at least 1");
    end

    estado_t       estado, prox;
    logic [CW-1:0] cnt, cnt_prox, cnt_inc;
    logic          pendente, pend_prox;
    logic          primeiro, prim_prox;
    logic          timeout;

`ifdef TUSCA_UC_WATCHDOG_EN
    watchdog_uc #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .zera  (!is_espera(estado)),
        .conta (is_espera(estado)),
        .fim   (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            cnt      <= '0;
            pendente <= 1'b0;
            primeiro <= 1'b0;
        end else begin
            estado   <= prox;
            cnt      <= cnt_prox;
            pendente <= pend_prox;
            primeiro <= prim_prox;
        end
    end

    // Saturating failure count; retry target chosen per wait state
    assign cnt_inc = (cnt == MAXC) ? cnt : cnt + 1'b1;

    always_comb begin
        prox      = estado;
        cnt_prox  = cnt;
        pend_prox = pendente | atualizar_config;
        prim_prox = 1'b0;
        if (!ligar) begin
            prox      = INICIAL;
            cnt_prox  = '0;
            pend_prox = 1'b0;
        end else begin
            unique case (estado)
                INICIAL:     prox = PEDE_CONFIG;
                PEDE_CONFIG: prox = ESPERA_CONFIG;
                ESPERA_CONFIG: begin
                    if (dp.erro_config || timeout) begin
                        cnt_prox = cnt_inc;
                        prox = (cnt_inc >= MAXC) ? ERRO : PEDE_CONFIG;
                    end else if (dp.pronto_config) begin
                        cnt_prox = '0;
                        prox     = MEDE;
                    end
                end
                MEDE: prox = ESPERA_MEDIDA;
                ESPERA_MEDIDA: begin
                    if (dp.erro_medida || timeout) begin
                        cnt_prox = cnt_inc;
                        prox = (cnt_inc >= MAXC) ? ERRO : MEDE;
                    end else if (dp.pronto_medida) begin
                        cnt_prox = '0;
                        prox     = TRANSMITE;
                    end
                end
                TRANSMITE: prox = ESPERA_TRANSMITE;
                ESPERA_TRANSMITE: begin
                    if (timeout) begin
                        prox = ERRO;
                    end else if (dp.pronto_transmite_medida) begin
                        prox      = AGUARDA;
                        prim_prox = 1'b1;
                    end
                end
                AGUARDA: begin
                    if (dp.fim_delay) begin
                        prox = (pendente || atualizar_config) ?
                               PEDE_CONFIG : MEDE;
                    end
                end
                ERRO:    prox = ERRO;
                default: prox = INICIAL;
            endcase
            if (prox == PEDE_CONFIG && estado != PEDE_CONFIG) begin
                pend_prox = 1'b0;
            end
        end
    end

    always_comb begin
        dp.receber_config   = 1'b0;
        dp.medir_dht11      = 1'b0;
        dp.transmite_medida = 1'b0;
        dp.zera_delay       = 1'b0;
        dp.conta_delay      = 1'b0;
        dp.gira             = 1'b0;
        pronto_ciclo        = 1'b0;
        erro                = 1'b0;
        unique case (estado)
            PEDE_CONFIG: dp.receber_config = 1'b1;
            MEDE: begin
                dp.medir_dht11 = 1'b1;
                dp.zera_delay  = 1'b1;
            end
            TRANSMITE: dp.transmite_medida = 1'b1;
            AGUARDA: begin
                dp.conta_delay = 1'b1;
                dp.gira        = 1'b1;
                pronto_ciclo   = primeiro;
            end
            ERRO:    erro = 1'b1;
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_tusca_uc.sv
// Directed + randomized bench for tusca_uc with pulse-count reference model.
module tb_tusca_uc;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       atualizar_config;
    logic       pronto_ciclo;
    logic       erro;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    int n_rcv = 0, n_med = 0, n_tx = 0, n_ciclo = 0;
    int exp_rcv = 0, exp_med = 0, exp_tx = 0, exp_ciclo = 0;

    localparam int P_CFG = 0, E_CFG = 1, P_MED = 2, E_MED = 3;
    localparam int P_TX = 4, FIM = 5, ATU = 6;

    localparam int S_INI = 0, S_PEDE = 1, S_ECFG = 2, S_MEDE = 3;
    localparam int S_EMED = 4, S_TX = 5, S_ETX = 6, S_AGU = 7, S_ERRO = 15;

    tusca_uc_if bus ();

    tusca_uc #(
        .MAX_TENTATIVAS(3),
        .TIMEOUT_CICLOS(10)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ligar            (ligar),
        .atualizar_config (atualizar_config),
        .dp               (bus.master),
        .pronto_ciclo     (pronto_ciclo),
        .erro             (erro),
        .db_estado        (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.receber_config)   n_rcv   <= n_rcv + 1;
        if (bus.medir_dht11)      n_med   <= n_med + 1;
        if (bus.transmite_medida) n_tx    <= n_tx + 1;
        if (pronto_ciclo)         n_ciclo <= n_ciclo + 1;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic set_in(int k, logic v);
        case (k)
            P_CFG:   bus.pronto_config = v;
            E_CFG:   bus.erro_config = v;
            P_MED:   bus.pronto_medida = v;
            E_MED:   bus.erro_medida = v;
            P_TX:    bus.pronto_transmite_medida = v;
            FIM:     bus.fim_delay = v;
            default: atualizar_config = v;
        endcase
    endtask

    task automatic pulse(int k);
        set_in(k, 1'b1);
        tick();
        set_in(k, 1'b0);
    endtask

    function automatic logic [5:0] cmds();
        return {bus.receber_config, bus.medir_dht11, bus.transmite_medida,
                bus.zera_delay, bus.conta_delay, bus.gira};
    endfunction

    initial begin
        int errs, upd, both, ncfg, n;
        reset = 1'b0;
        ligar = 1'b0;
        for (int k = 0; k <= ATU; k++) set_in(k, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", db_estado, S_INI);
        chk("rst_cmds", cmds(), 0);
        chk("rst_erro", erro, 0);
        chk("rst_ciclo", pronto_ciclo, 0);
        reset = 1'b1;
        idle(2);
        chk("idle_ligar0", db_estado, S_INI);

        ligar = 1'b1;
        tick();
        chk("pede_state", db_estado, S_PEDE);
        chk("pede_rcv", bus.receber_config, 1);
        exp_rcv++;
        tick();
        chk("ecfg_state", db_estado, S_ECFG);
        chk("ecfg_rcv_off", bus.receber_config, 0);
        idle($urandom_range(0, 4));
        chk("ecfg_wait", db_estado, S_ECFG);
        pulse(P_CFG);
        chk("mede_state", db_estado, S_MEDE);
        chk("mede_cmds", cmds(), 6'b010100);
        exp_med++;
        tick();
        chk("emed_state", db_estado, S_EMED);
        pulse(P_MED);
        chk("tx_cmds", cmds(), 6'b001000);
        exp_tx++;
        tick();
        chk("etx_state", db_estado, S_ETX);
        pulse(P_TX);
        chk("agu_state", db_estado, S_AGU);
        chk("agu_ciclo", pronto_ciclo, 1);
        chk("agu_cmds", cmds(), 6'b000011);
        exp_ciclo++;
        tick();
        chk("agu_ciclo_once", pronto_ciclo, 0);
        pulse(FIM);
        chk("loop_mede", db_estado, S_MEDE);
        exp_med++;

        for (int it = 0; it < 8; it++) begin
            errs = $urandom_range(0, 2);
            upd  = $urandom_range(0, 1);
            tick();
            chk("r_emed", db_estado, S_EMED);
            for (int e = 0; e < errs; e++) begin
                idle($urandom_range(0, 3));
                both = $urandom_range(0, 1);
                bus.erro_medida   = 1'b1;
                bus.pronto_medida = both[0];
                tick();
                bus.erro_medida   = 1'b0;
                bus.pronto_medida = 1'b0;
                chk("r_retry", db_estado, S_MEDE);
                exp_med++;
                tick();
                chk("r_emed2", db_estado, S_EMED);
            end
            idle($urandom_range(0, 3));
            pulse(P_MED);
            chk("r_tx", db_estado, S_TX);
            exp_tx++;
            tick();
            if (upd != 0) pulse(ATU);
            chk("r_etx", db_estado, S_ETX);
            pulse(P_TX);
            chk("r_agu", db_estado, S_AGU);
            exp_ciclo++;
            idle($urandom_range(0, 3));
            pulse(FIM);
            if (upd != 0) begin
                chk("r_pede", db_estado, S_PEDE);
                exp_rcv++;
                tick();
                ncfg = $urandom_range(0, 2);
                for (int c = 0; c < ncfg; c++) begin
                    pulse(E_CFG);
                    chk("r_cfg_retry", db_estado, S_PEDE);
                    exp_rcv++;
                    tick();
                end
                pulse(P_CFG);
            end
            chk("r_mede", db_estado, S_MEDE);
            exp_med++;
        end

        tick();
        chk("cnt_rcv", n_rcv, exp_rcv);
        chk("cnt_med", n_med, exp_med);
        chk("cnt_tx", n_tx, exp_tx);
        chk("cnt_ciclo", n_ciclo, exp_ciclo);

        pulse(E_MED);
        chk("e1_mede", db_estado, S_MEDE);
        tick();
        pulse(E_MED);
        chk("e2_mede", db_estado, S_MEDE);
        tick();
        pulse(E_MED);
        chk("e3_erro", db_estado, S_ERRO);
        chk("erro_flag", erro, 1);
        chk("erro_cmds", cmds(), 0);
        bus.pronto_config = 1'b1;
        bus.fim_delay     = 1'b1;
        idle(3);
        bus.pronto_config = 1'b0;
        bus.fim_delay     = 1'b0;
        chk("erro_sticky", db_estado, S_ERRO);
        ligar = 1'b0;
        tick();
        chk("erro_exit", db_estado, S_INI);
        chk("erro_clear", erro, 0);

        ligar = 1'b1;
        tick();
        tick();
        pulse(P_CFG);
        tick();
        chk("pre_rst", db_estado, S_EMED);
        #2 reset = 1'b0;
        #1;
        chk("arst_state", db_estado, S_INI);
        chk("arst_cmds", cmds(), 0);
        ligar = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(3);
        chk("arst_hold", db_estado, S_INI);

        ligar = 1'b1;
        tick();
        tick();
        chk("off_pre", db_estado, S_ECFG);
        ligar = 1'b0;
        tick();
        chk("off_ini", db_estado, S_INI);

`ifdef TUSCA_UC_WATCHDOG_EN
        ligar = 1'b1;
        tick();
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("wd_ecfg", db_estado, S_ECFG);
            n = 0;
            while (db_estado == S_ECFG && n < 100) begin
                tick();
                n++;
            end
            chk("wd_cycles", n, 10);
            chk("wd_next", db_estado, (t < 2) ? S_PEDE : S_ERRO);
        end
        ligar = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tusca_uc.md
TUSCA_UC -- requirements
Module: tusca_uc

Interface
REQ-001 Parameter MAX_TENTATIVAS, default 3: consecutive failed config/measurement attempts allowed before ERRO.
REQ-002 Parameter TIMEOUT_CICLOS, default 50_000_000: watchdog limit in clock cycles for any wait state.
REQ-003 clock  in  1  system clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ligar  in  1  level; 1 = system running, 0 = return to INICIAL.
REQ-006 atualizar_config  in  1  one-cycle request to reload configuration.
REQ-007 pronto_config, erro_config, pronto_medida, erro_medida, pronto_transmite_medida, fim_delay  in  1 each  datapath status pulses.
REQ-008 receber_config, medir_dht11, transmite_medida  out  1 each  one-cycle command pulses to the datapath.
REQ-009 zera_delay, conta_delay, gira  out  1 each  delay-counter clear/enable and servo enable.
REQ-010 pronto_ciclo  out  1  one-cycle pulse when a measurement is transmitted.
REQ-011 erro  out  1  sticky fault flag.
REQ-012 db_estado  out  4  current state encoding.

Function
REQ-013 States and encodings: INICIAL 0, PEDE_CONFIG 1, ESPERA_CONFIG 2, MEDE 3, ESPERA_MEDIDA 4, TRANSMITE 5, ESPERA_TRANSMITE 6, AGUARDA 7, ERRO 15.
REQ-014 All outputs are Moore-decoded from registered state; no output depends combinationally on inputs.
REQ-015 INICIAL: goes to PEDE_CONFIG on ligar=1 (command pulse one cycle after ligar is sampled).
REQ-016 PEDE_CONFIG: receber_config=1 for exactly one cycle, then ESPERA_CONFIG.
REQ-017 ESPERA_CONFIG: pronto_config goes to MEDE and clears the attempt counter; erro_config increments it and goes to PEDE_CONFIG, or to ERRO when the counter reaches MAX_TENTATIVAS.
REQ-018 MEDE: medir_dht11=1 and zera_delay=1 for one cycle, then ESPERA_MEDIDA.
REQ-019 ESPERA_MEDIDA: pronto_medida goes to TRANSMITE and clears the counter; erro_medida goes to MEDE or ERRO under the same counting rule as REQ-017.
REQ-020 TRANSMITE: transmite_medida=1 for one cycle, then ESPERA_TRANSMITE.
REQ-021 ESPERA_TRANSMITE: pronto_transmite_medida goes to AGUARDA, with pronto_ciclo=1 in the first AGUARDA cycle.
REQ-022 AGUARDA: conta_delay=1 and gira=1; fim_delay goes to PEDE_CONFIG if a config request is pending, else to MEDE.
REQ-023 atualizar_config sets a pending flag in any state; the flag is cleared on entry to PEDE_CONFIG.
REQ-024 Simultaneous pronto and erro in the same cycle: erro takes priority.
REQ-025 ligar=0 in any state except ERRO forces INICIAL on the next edge and clears the counter and pending flag.
REQ-026 ERRO: erro=1 and all commands are 0; the FSM leaves ERRO to INICIAL only when ligar=0.
REQ-027 Attempt counter width is $clog2(MAX_TENTATIVAS+1) and the counter saturates, never wrapping.

Reset
REQ-028 On reset=0: state INICIAL, counter 0, pending flag 0, watchdog 0, all outputs 0, db_estado 0; reset takes effect immediately, mid-operation included.

Configuration
REQ-029 When macro TUSCA_UC_WATCHDOG_EN is defined: a counter runs in each ESPERA_* state, clears on state change, and on reaching TIMEOUT_CICLOS counts as one failed attempt (REQ-017/019 rules; ESPERA_TRANSMITE goes to ERRO directly).
REQ-030 When TUSCA_UC_WATCHDOG_EN is undefined: no watchdog logic exists and wait states wait indefinitely.

Structure
REQ-031 A shared package tusca_pkg holds the state typedef and encodings plus the db_estado width constant.
REQ-032 The watchdog is a sub-module, watchdog_uc (clock, reset, zera, conta, fim), instantiated only under TUSCA_UC_WATCHDOG_EN.

Verification
REQ-033 Reset, ligar=1, config ok, medida ok, tx ok, fim_delay: pulse sequence receber_config, medir_dht11, transmite_medida; pronto_ciclo once; loop returns to MEDE.
REQ-034 erro_medida three times in a row (MAX_TENTATIVAS=3): two MEDE retries, then ERRO with erro=1 and db_estado=15; ligar=0 returns to INICIAL.
REQ-035 pronto_medida and erro_medida in the same cycle: FSM counts an error and does not reach TRANSMITE.
REQ-036 atualizar_config pulsed during ESPERA_TRANSMITE: next fim_delay leads to PEDE_CONFIG, not MEDE.
REQ-037 With TUSCA_UC_WATCHDOG_EN and TIMEOUT_CICLOS=10, no pronto_config: re-request after 10 cycles, ERRO after the third timeout.
REQ-038 reset asserted mid-ESPERA_MEDIDA: all outputs are 0 immediately, and INICIAL is held after reset deasserts with ligar=0.
